tlb_frontend: RTL and testbench

- Parametrised multi-port TLB front end that replaces the fixed two-port instruction/data micro-TLB wrapper.
- Each of NPORT search ports owns a private fully-associative micro-TLB (uTLB) of UTLB_DEPTH entries.
- uTLB misses go to a single shared L2 lookup port, with round-robin arbitration between ports.
- Sits between the pipeline address-translation stages and tlb_L2; the L2 still owns TLBRD/TLBWR/INVTLB state.

---
 rtl/tlb_frontend.sv | 257 +++++++++++++++++++++++++
 tb/tb_tlb_frontend.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_frontend.sv
// Multi-port translation front end: private fully-associative uTLB per search port,
// misses share one round-robin arbitrated L2 lookup port. Define TLB_FRONT_PERF_EN for hit/miss counters.
package tlb_pkg;
    localparam int TLB_IDX_W = 4;

    typedef struct packed {
        logic [18:0] vppn;
        logic        ps4mb;
        logic        g;
        logic [9:0]  asid;
        logic        e;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef struct packed {
        logic                 found;
        logic [TLB_IDX_W-1:0] index;
        logic [5:0]           ps;
        logic [19:0]          ppn;
        logic [1:0]           plv;
        logic [1:0]           mat;
        logic                 d;
        logic                 v;
    } tlb_result_t;
endpackage

module tlb_frontend
    import tlb_pkg::*;
#(
    parameter int NPORT      = 2,
    parameter int UTLB_DEPTH = 4,
    parameter int TLBIDLEN   = tlb_pkg::TLB_IDX_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NPORT-1:0]          s_valid,
    input  logic [NPORT*19-1:0]       s_vppn,
    input  logic [NPORT-1:0]          s_va_bit12,
    input  logic [NPORT*10-1:0]       s_asid,
    output logic [NPORT-1:0]          s_ok,
    output tlb_result_t [NPORT-1:0]   s_result,
    output logic                      l2_req,
    output logic [18:0]               l2_vppn,
    output logic [9:0]                l2_asid,
    input  logic                      l2_found,
    input  logic [TLBIDLEN-1:0]       l2_index,
    input  tlb_entry_t                l2_entry,
    input  logic                      flush
`ifdef TLB_FRONT_PERF_EN
    ,
    output logic [NPORT*32-1:0]       perf_hit,
    output logic [NPORT*32-1:0]       perf_miss
`endif
);

    // state  | meaning
    // LOOKUP | searching the uTLB, 0-cycle hit response
    // REQ    | missed, waiting for an L2 grant
    // RESP   | L2 result arrives this cycle
    typedef enum logic [1:0] {LOOKUP, REQ, RESP} state_t;

    localparam int VW = $clog2(UTLB_DEPTH);
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    state_t                st_q     [NPORT];
    state_t                st_d     [NPORT];
    logic [UTLB_DEPTH-1:0] vld_q    [NPORT];
    tlb_entry_t            ent_q    [NPORT][UTLB_DEPTH];
    logic [TLBIDLEN-1:0]   idx_q    [NPORT][UTLB_DEPTH];
    logic [VW-1:0]         vic_q    [NPORT];
    logic [NPORT-1:0]      stale_q;
    logic [PW-1:0]         rr_q;

    logic [18:0]           vppn     [NPORT];
    logic [9:0]            asid     [NPORT];
    logic [NPORT-1:0]      hit;
    logic [VW-1:0]         hit_slot [NPORT];
    logic [NPORT-1:0]      gnt;
    logic                  gnt_any;
    logic [PW-1:0]         gnt_port;
    logic [NPORT-1:0]      refill;
    logic [VW-1:0]         wr_slot  [NPORT];

    function automatic logic entry_match(tlb_entry_t ent, logic [18:0] va, logic [9:0] as);
        logic vmatch;
        vmatch = ent.ps4mb ? (ent.vppn[18:9] == va[18:9]) : (ent.vppn == va);
        return ent.e && (ent.g || (ent.asid == as)) && vmatch;
    endfunction

    function automatic tlb_result_t make_result(tlb_entry_t ent, logic [TLBIDLEN-1:0] idx,
                                                logic [18:0] va, logic va12);
        tlb_result_t r;
        logic        odd;
        odd     = ent.ps4mb ? va[8] : va12;
        r       = '0;
        r.found = 1'b1;
        r.index = TLB_IDX_W'(idx);
        r.ps    = ent.ps4mb ? 6'd21 : 6'd12;
        r.ppn   = odd ? ent.ppn1 : ent.ppn0;
        r.plv   = odd ? ent.plv1 : ent.plv0;
        r.mat   = odd ? ent.mat1 : ent.mat0;
        r.d     = odd ? ent.d1   : ent.d0;
        r.v     = odd ? ent.v1   : ent.v0;
        return r;
    endfunction

    // Lowest matching slot wins; scanning downward avoids reading back partial results.
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            vppn[p]     = s_vppn[p*19 +: 19];
            asid[p]     = s_asid[p*10 +: 10];
            hit[p]      = 1'b0;
            hit_slot[p] = '0;
            for (int s = UTLB_DEPTH - 1; s >= 0; s--) begin
                if (vld_q[p][s] && entry_match(ent_q[p][s], vppn[p], asid[p])) begin
                    hit[p]      = 1'b1;
                    hit_slot[p] = VW'(s);
                end
            end
        end
    end

    always_comb begin
        gnt      = '0;
        gnt_any  = 1'b0;
        gnt_port = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (!gnt_any && st_q[(int'(rr_q) + i) % NPORT] == REQ) begin
                gnt_any  = 1'b1;
                gnt_port = PW'((int'(rr_q) + i) % NPORT);
            end
        end
        if (gnt_any) gnt[gnt_port] = 1'b1;
    end

    always_comb begin
        l2_req  = gnt_any && !reset;
        l2_vppn = vppn[gnt_port];
        l2_asid = asid[gnt_port];
    end

    always_comb begin
        s_ok   = '0;
        refill = '0;
        for (int p = 0; p < NPORT; p++) begin
            st_d[p]     = st_q[p];
            s_result[p] = '0;
            wr_slot[p]  = hit[p] ? hit_slot[p] : vic_q[p];
            case (st_q[p])
                LOOKUP: begin
                    if (s_valid[p]) begin
                        if (!hit[p]) begin
                            st_d[p] = REQ;
                        end else if (!flush) begin
                            s_ok[p]     = 1'b1;
                            s_result[p] = make_result(ent_q[p][hit_slot[p]], idx_q[p][hit_slot[p]],
                                                      vppn[p], s_va_bit12[p]);
                        end
                    end
                end
                REQ: begin
                    if (gnt[p]) st_d[p] = RESP;
                end
                RESP: begin
                    // A response overlapping a flush may be stale, so the lookup is re-issued.
                    if (flush || stale_q[p]) begin
                        st_d[p] = REQ;
                    end else begin
                        st_d[p] = LOOKUP;
                        s_ok[p] = 1'b1;
                        if (l2_found) begin
                            refill[p]   = 1'b1;
                            s_result[p] = make_result(l2_entry, l2_index, vppn[p], s_va_bit12[p]);
                        end
                    end
                end
                default: st_d[p] = LOOKUP;
            endcase
            if (reset) begin
                s_ok[p]     = 1'b0;
                s_result[p] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q    <= '0;
            stale_q <= '0;
            for (int p = 0; p < NPORT; p++) begin
                st_q[p]  <= LOOKUP;
                vld_q[p] <= '0;
                vic_q[p] <= '0;
            end
        end else begin
            stale_q <= gnt & {NPORT{flush}};
            if (gnt_any) rr_q <= (gnt_port == PW'(NPORT - 1)) ? '0 : gnt_port + 1'b1;
            for (int p = 0; p < NPORT; p++) begin
                st_q[p] <= st_d[p];
                if (flush) begin
                    vld_q[p] <= '0;
                end else if (refill[p]) begin
                    vld_q[p][wr_slot[p]] <= 1'b1;
                    // A duplicate overwrites its existing slot and leaves the victim pointer alone.
                    if (!hit[p]) vic_q[p] <= vic_q[p] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (!reset && refill[p]) begin
                ent_q[p][wr_slot[p]] <= l2_entry;
                idx_q[p][wr_slot[p]] <= l2_index;
            end
        end
    end

`ifdef TLB_FRONT_PERF_EN
    logic [31:0] hit_cnt_q  [NPORT];
    logic [31:0] miss_cnt_q [NPORT];

    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (reset) begin
                hit_cnt_q[p]  <= '0;
                miss_cnt_q[p] <= '0;
            end else begin
                if (s_ok[p] && st_q[p] == LOOKUP && hit_cnt_q[p] != '1)
                    hit_cnt_q[p] <= hit_cnt_q[p] + 32'd1;
                if (st_d[p] == REQ && st_q[p] != REQ && miss_cnt_q[p] != '1)
                    miss_cnt_q[p] <= miss_cnt_q[p] + 32'd1;
            end
        end
    end

    always_comb begin
        perf_hit  = '0;
        perf_miss = '0;
        for (int p = 0; p < NPORT; p++) begin
            perf_hit[p*32 +: 32]  = hit_cnt_q[p];
            perf_miss[p*32 +: 32] = miss_cnt_q[p];
        end
    end
`endif

endmodule

// File: tb/tb_tlb_frontend.sv
// Directed bench for tlb_frontend (NPORT=2, UTLB_DEPTH=4): misses, hits, arbitration, pages, replacement, flush.
module tb_tlb_frontend;
    import tlb_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [1:0]           s_valid;
    logic [37:0]          s_vppn;
    logic [1:0]           s_va_bit12;
    logic [19:0]          s_asid;
    logic [1:0]           s_ok;
    tlb_result_t [1:0]    s_result;
    logic                 l2_req;
    logic [18:0]          l2_vppn;
    logic [9:0]           l2_asid;
    logic                 l2_found;
    logic [3:0]           l2_index;
    tlb_entry_t           l2_entry;
    logic                 flush;
`ifdef TLB_FRONT_PERF_EN
    logic [63:0]          perf_hit;
    logic [63:0]          perf_miss;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tlb_frontend #(.NPORT(2), .UTLB_DEPTH(4), .TLBIDLEN(4)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
        .s_ok(s_ok), .s_result(s_result),
        .l2_req(l2_req), .l2_vppn(l2_vppn), .l2_asid(l2_asid),
        .l2_found(l2_found), .l2_index(l2_index), .l2_entry(l2_entry),
        .flush(flush)
`ifdef TLB_FRONT_PERF_EN
        , .perf_hit(perf_hit), .perf_miss(perf_miss)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic tlb_entry_t mk(input logic [18:0] v, input logic [9:0] a, input logic ps4mb,
                                      input logic [19:0] p0, input logic [19:0] p1);
        tlb_entry_t e;
        e       = '0;
        e.vppn  = v;
        e.asid  = a;
        e.ps4mb = ps4mb;
        e.e     = 1'b1;
        e.ppn0  = p0;
        e.ppn1  = p1;
        e.v0    = 1'b1;
        e.v1    = 1'b1;
        return e;
    endfunction

    task automatic present(input int p, input logic [18:0] v, input logic [9:0] a, input logic b12);
        s_valid[p]          = 1'b1;
        s_vppn[p*19 +: 19]  = v;
        s_asid[p*10 +: 10]  = a;
        s_va_bit12[p]       = b12;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        s_valid  = '0;
        flush    = 1'b0;
        l2_found = 1'b0;
        l2_entry = '0;
        l2_index = '0;
        tick();
        tick();
        chk("rst_s_ok", 32'(s_ok), 32'd0);
        chk("rst_l2_req", 32'(l2_req), 32'd0);
        chk("rst_result", 32'(s_result != '0), 32'd0);
        reset = 1'b0;
    endtask

    task automatic miss(input string tag, input int p, input logic [18:0] v, input logic [9:0] a,
                        input logic b12, input logic found, input tlb_entry_t ent,
                        input logic [19:0] eppn, input logic [5:0] eps);
        tick();
        present(p, v, a, b12);
        l2_found = 1'b0;
        #1;
        chk({tag, "_c0_ok"}, 32'(s_ok[p]), 32'd0);
        chk({tag, "_c0_req"}, 32'(l2_req), 32'd0);
        tick();
        #1;
        chk({tag, "_c1_req"}, 32'(l2_req), 32'd1);
        chk({tag, "_c1_vppn"}, 32'(l2_vppn), 32'(v));
        chk({tag, "_c1_asid"}, 32'(l2_asid), 32'(a));
        tick();
        l2_found = found;
        l2_entry = ent;
        #1;
        chk({tag, "_c2_ok"}, 32'(s_ok[p]), 32'd1);
        chk({tag, "_c2_found"}, 32'(s_result[p].found), 32'(found));
        if (found) begin
            chk({tag, "_c2_ppn"}, 32'(s_result[p].ppn), 32'(eppn));
            chk({tag, "_c2_ps"}, 32'(s_result[p].ps), 32'(eps));
        end
        s_valid[p] = 1'b0;
    endtask

    task automatic hit(input string tag, input int p, input logic [18:0] v, input logic [9:0] a,
                       input logic b12, input logic [19:0] eppn, input logic [5:0] eps);
        tick();
        present(p, v, a, b12);
        l2_found = 1'b0;
        #1;
        chk({tag, "_ok"}, 32'(s_ok[p]), 32'd1);
        chk({tag, "_noreq"}, 32'(l2_req), 32'd0);
        chk({tag, "_ppn"}, 32'(s_result[p].ppn), 32'(eppn));
        chk({tag, "_ps"}, 32'(s_result[p].ps), 32'(eps));
        s_valid[p] = 1'b0;
    endtask

    initial begin
        s_vppn     = '0;
        s_asid     = '0;
        s_va_bit12 = '0;
        do_reset();

        // cold miss then 0-cycle repeat hit
        miss("cold", 0, 19'h00012, 10'd1, 1'b0, 1'b1, mk(19'h00012, 10'd1, 1'b0, 20'hABCDE, 20'h12345),
             20'hABCDE, 6'd12);
        hit("cold_rep", 0, 19'h00012, 10'd1, 1'b0, 20'hABCDE, 6'd12);

        // simultaneous misses, pointer at port 0 after reset
        do_reset();
        tick();
        present(0, 19'h00100, 10'd1, 1'b0);
        present(1, 19'h00200, 10'd1, 1'b0);
        #1;
        chk("arb_c0_ok", 32'(s_ok), 32'd0);
        tick();
        #1;
        chk("arb_c1_req", 32'(l2_req), 32'd1);
        chk("arb_c1_vppn", 32'(l2_vppn), 32'h00100);
        tick();
        l2_found = 1'b1;
        l2_entry = mk(19'h00100, 10'd1, 1'b0, 20'h11111, 20'h0);
        #1;
        chk("arb_c2_ok", 32'(s_ok), 32'd1);
        chk("arb_c2_ppn", 32'(s_result[0].ppn), 32'h11111);
        chk("arb_c2_req", 32'(l2_req), 32'd1);
        chk("arb_c2_vppn", 32'(l2_vppn), 32'h00200);
        s_valid[0] = 1'b0;
        tick();
        l2_entry = mk(19'h00200, 10'd1, 1'b0, 20'h22222, 20'h0);
        #1;
        chk("arb_c3_ok", 32'(s_ok), 32'd2);
        chk("arb_c3_ppn", 32'(s_result[1].ppn), 32'h22222);
        chk("arb_c3_noreq", 32'(l2_req), 32'd0);
        s_valid[1] = 1'b0;

        // single port0 grant moves the pointer to port 1
        miss("ptr", 0, 19'h00300, 10'd1, 1'b0, 1'b1, mk(19'h00300, 10'd1, 1'b0, 20'h33333, 20'h0),
             20'h33333, 6'd12);
        tick();
        present(0, 19'h00400, 10'd1, 1'b0);
        present(1, 19'h00500, 10'd1, 1'b0);
        l2_found = 1'b0;
        #1;
        tick();
        #1;
        chk("rearb_c1_vppn", 32'(l2_vppn), 32'h00500);
        tick();
        l2_found = 1'b1;
        l2_entry = mk(19'h00500, 10'd1, 1'b0, 20'h55555, 20'h0);
        #1;
        chk("rearb_c2_ok", 32'(s_ok), 32'd2);
        chk("rearb_c2_ppn", 32'(s_result[1].ppn), 32'h55555);
        chk("rearb_c2_vppn", 32'(l2_vppn), 32'h00400);
        s_valid[1] = 1'b0;
        tick();
        l2_entry = mk(19'h00400, 10'd1, 1'b0, 20'h44444, 20'h0);
        #1;
        chk("rearb_c3_ok", 32'(s_ok), 32'd1);
        chk("rearb_c3_ppn", 32'(s_result[0].ppn), 32'h44444);
        s_valid[0] = 1'b0;

        // page selection: 4MB uses vppn[8], 4KB uses va_bit12
        miss("pg4m", 1, 19'h40100, 10'd3, 1'b0, 1'b1, mk(19'h40000, 10'd3, 1'b1, 20'h0AAAA, 20'h0BBBB),
             20'h0BBBB, 6'd21);
        hit("pg4m_even", 1, 19'h40000, 10'd3, 1'b1, 20'h0AAAA, 6'd21);
        miss("pg4k", 1, 19'h00777, 10'd3, 1'b1, 1'b1, mk(19'h00777, 10'd3, 1'b0, 20'h0CCCC, 20'h0DDDD),
             20'h0DDDD, 6'd12);
        hit("pg4k_even", 1, 19'h00777, 10'd3, 1'b0, 20'h0CCCC, 6'd12);
        miss("asid_mis", 1, 19'h00777, 10'd4, 1'b0, 1'b0, '0, 20'h0, 6'd0);

        // replacement wrap: fifth miss evicts slot 0
        do_reset();
        for (int i = 0; i < 5; i++)
            miss("repl", 0, 19'(19'h01000 + i), 10'd1, 1'b0, 1'b1,
                 mk(19'(19'h01000 + i), 10'd1, 1'b0, 20'(20'h10000 + i), 20'h0),
                 20'(20'h10000 + i), 6'd12);
        hit("repl_keep1", 0, 19'h01001, 10'd1, 1'b0, 20'h10001, 6'd12);
        hit("repl_keep4", 0, 19'h01004, 10'd1, 1'b0, 20'h10004, 6'd12);
        miss("repl_evict0", 0, 19'h01000, 10'd1, 1'b0, 1'b1, mk(19'h01000, 10'd1, 1'b0, 20'h1F000, 20'h0),
             20'h1F000, 6'd12);

        // flush during RESP discards the response and re-issues
        tick();
        present(0, 19'h02000, 10'd1, 1'b0);
        #1;
        chk("race_c0_ok", 32'(s_ok[0]), 32'd0);
        tick();
        #1;
        chk("race_c1_req", 32'(l2_req), 32'd1);
        tick();
        l2_found = 1'b1;
        l2_entry = mk(19'h02000, 10'd1, 1'b0, 20'h20000, 20'h0);
        flush    = 1'b1;
        #1;
        chk("race_c2_ok", 32'(s_ok[0]), 32'd0);
        tick();
        flush    = 1'b0;
        l2_found = 1'b0;
        #1;
        chk("race_c3_req", 32'(l2_req), 32'd1);
        chk("race_c3_vppn", 32'(l2_vppn), 32'h02000);
        chk("race_c3_ok", 32'(s_ok[0]), 32'd0);
        tick();
        l2_found = 1'b1;
        #1;
        chk("race_c4_ok", 32'(s_ok[0]), 32'd1);
        chk("race_c4_ppn", 32'(s_result[0].ppn), 32'h20000);
        s_valid[0] = 1'b0;
        miss("post_flush", 0, 19'h01002, 10'd1, 1'b0, 1'b1, mk(19'h01002, 10'd1, 1'b0, 20'h10002, 20'h0),
             20'h10002, 6'd12);
        hit("race_cached", 0, 19'h02000, 10'd1, 1'b0, 20'h20000, 6'd12);

        // hit suppressed while flush is asserted, and the entry is gone afterwards
        tick();
        present(0, 19'h02000, 10'd1, 1'b0);
        flush = 1'b1;
        #1;
        chk("flush_hit_supp", 32'(s_ok[0]), 32'd0);
        s_valid[0] = 1'b0;
        tick();
        flush = 1'b0;
        miss("flush_gone", 0, 19'h02000, 10'd1, 1'b0, 1'b1, mk(19'h02000, 10'd1, 1'b0, 20'h20000, 20'h0),
             20'h20000, 6'd12);

        // L2 miss is reported and not cached
        miss("l2miss", 1, 19'h05555, 10'd2, 1'b0, 1'b0, '0, 20'h0, 6'd0);
        miss("l2miss_again", 1, 19'h05555, 10'd2, 1'b0, 1'b1, mk(19'h05555, 10'd2, 1'b0, 20'h55AAA, 20'h0),
             20'h55AAA, 6'd12);
        hit("l2miss_cached", 1, 19'h05555, 10'd2, 1'b0, 20'h55AAA, 6'd12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
